// File: rtl/eth_pkg.sv
// Shared state encoding, header constants and small helpers for the Ethernet RX frame parser.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DROP,
    HOLD
  } state_t;

  localparam int          HDR_WORDS = 7;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  // Bus words carry the first wire byte in [7:0]; this yields wire (big-endian) order.
  function automatic logic [15:0] swap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_rx_payload_ram.sv
// Simple dual-port payload buffer: one write port, registered read port (1-cycle latency).
// No reset on the array so it maps onto block RAM.
module eth_rx_payload_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk40m,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk40m) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_rx_frame_parser.sv
// Parses the 16-bit RX word stream, filters on destination MAC and EtherType, buffers one payload.
// rd_data has 1-cycle latency; while a frame is held, new frames are discarded and counted as drops.
module eth_rx_frame_parser
  import eth_pkg::*;
#(
  parameter logic [47:0] MY_MAC    = 48'h0A0B0C0D0E0F,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          ADDR_W    = 9
) (
  input  logic              clk40m,
  input  logic              reset,
  input  logic [15:0]       rx_word,
  input  logic              rx_valid,
  input  logic              rx_sof,
  input  logic              rx_eof,
  input  logic              rx_err,
  output logic              frame_ready,
  output logic [ADDR_W:0]   frame_words,
  output logic [47:0]       src_mac,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  input  logic              frame_ack,
  output logic              drop_pulse,
  output logic [15:0]       drop_count
);

  localparam logic [2:0] LAST_HDR = 3'(HDR_WORDS - 1);

  state_t            state;
  logic [2:0]        hdr_cnt;
  logic [47:0]       dst_sr;
  logic [47:0]       src_sr;
  logic [ADDR_W-1:0] wptr;
  logic              hold_skip;

  logic              sof_w;
  logic              eof_w;
  logic              hdr_match;
  logic              ram_we;
  logic [ADDR_W:0]   wlen;

  always_comb begin
    sof_w     = rx_valid & rx_sof;
    eof_w     = rx_valid & rx_eof;
    hdr_match = ((dst_sr == MY_MAC) || (dst_sr == BCAST_MAC)) &&
                (swap16(rx_word) == ETHERTYPE);
    ram_we    = (state == PAYLOAD) && rx_valid && !rx_sof && !rx_err;
    wlen      = {1'b0, wptr} + {{ADDR_W{1'b0}}, 1'b1};
  end

  eth_rx_payload_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(16)
  ) u_ram (
    .clk40m(clk40m),
    .we    (ram_we),
    .waddr (wptr),
    .wdata (rx_word),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk40m) begin
    if (reset) begin
      state       <= IDLE;
      hdr_cnt     <= 3'd0;
      dst_sr      <= 48'h0;
      src_sr      <= 48'h0;
      wptr        <= '0;
      hold_skip   <= 1'b0;
      frame_ready <= 1'b0;
      frame_words <= '0;
      src_mac     <= 48'h0;
      drop_pulse  <= 1'b0;
      drop_count  <= 16'h0;
    end else begin
      drop_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sof_w) begin
            dst_sr  <= {32'h0, swap16(rx_word)};
            hdr_cnt <= 3'd1;
            state   <= HDR;
          end
        end

        HDR: begin
          if (rx_err) begin
            drop_pulse <= 1'b1;
            drop_count <= sat_inc16(drop_count);
            state      <= IDLE;
          end else if (sof_w) begin
            drop_pulse <= 1'b1;
            drop_count <= sat_inc16(drop_count);
            dst_sr     <= {32'h0, swap16(rx_word)};
            hdr_cnt    <= 3'd1;
          end else if (rx_valid) begin
            hdr_cnt <= hdr_cnt + 3'd1;
            if (hdr_cnt < 3'd3) begin
              dst_sr <= {dst_sr[31:0], swap16(rx_word)};
            end else if (hdr_cnt < LAST_HDR) begin
              src_sr <= {src_sr[31:0], swap16(rx_word)};
            end
            if (hdr_cnt == LAST_HDR) begin
              if (hdr_match && rx_eof) begin
                // Header-only frame: accepted with an empty payload.
                frame_words <= '0;
                frame_ready <= 1'b1;
                src_mac     <= src_sr;
                hold_skip   <= 1'b0;
                state       <= HOLD;
              end else if (hdr_match) begin
                wptr  <= '0;
                state <= PAYLOAD;
              end else begin
                drop_pulse <= 1'b1;
                drop_count <= sat_inc16(drop_count);
                state      <= rx_eof ? IDLE : DROP;
              end
            end else if (rx_eof) begin
              drop_pulse <= 1'b1;
              drop_count <= sat_inc16(drop_count);
              state      <= IDLE;
            end
          end
        end

        PAYLOAD: begin
          if (rx_err) begin
            drop_pulse <= 1'b1;
            drop_count <= sat_inc16(drop_count);
            state      <= IDLE;
          end else if (sof_w) begin
            drop_pulse <= 1'b1;
            drop_count <= sat_inc16(drop_count);
            dst_sr     <= {32'h0, swap16(rx_word)};
            hdr_cnt    <= 3'd1;
            state      <= HDR;
          end else if (rx_valid) begin
            wptr <= wptr + ADDR_W'(1);
            if (rx_eof) begin
              frame_words <= wlen;
              frame_ready <= 1'b1;
              src_mac     <= src_sr;
              hold_skip   <= 1'b0;
              state       <= HOLD;
            end else if (&wptr) begin
              // Buffer full and the frame keeps going: discard the rest.
              drop_pulse <= 1'b1;
              drop_count <= sat_inc16(drop_count);
              state      <= DROP;
            end
          end
        end

        DROP: begin
          if (rx_err) begin
            drop_pulse <= 1'b1;
            drop_count <= sat_inc16(drop_count);
            state      <= IDLE;
          end else if (eof_w) begin
            state <= IDLE;
          end
        end

        HOLD: begin
          if (sof_w) begin
            drop_pulse <= 1'b1;
            drop_count <= sat_inc16(drop_count);
          end
          // hold_skip tracks a rejected frame whose eof has not been seen yet.
          if (frame_ack) begin
            frame_ready <= 1'b0;
            hold_skip   <= 1'b0;
            state       <= ((sof_w && !rx_eof) || (hold_skip && !sof_w && !eof_w)) ? DROP : IDLE;
          end else if (sof_w) begin
            hold_skip <= !rx_eof;
          end else if (eof_w) begin
            hold_skip <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
